reg_write_arbiter: RTL and testbench

//   Owns the single write port of the 16x32 register bank. Arbitrates between the ALU writeback

---
 rtl/reg_bank_pkg.sv | 10 +
 rtl/rf_onehot_decode.sv | 18 +
 rtl/reg_write_arbiter.sv | 86 ++++++++
 tb/tb_reg_write_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared register-bank constants and types used by the write-port arbiter and its decoder.
package reg_bank_pkg;
  localparam int NREGS    = 16;
  localparam int ADDR_W   = $clog2(NREGS);
  localparam int DATA_W   = 32;
  localparam int REG_PC   = 15;
  localparam int MAX_WAIT = 3;

  typedef logic [NREGS-1:0] onehot_t;
endpackage

// File: rtl/rf_onehot_decode.sv
// Register index to one-hot bank enable; all-zero when i_en is low.
module rf_onehot_decode
  import reg_bank_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int N  = NREGS
) (
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  output logic [N-1:0]  o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_addr] = 1'b1;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Single write port of the register bank: ALU/LDR arbitration with bounded ALU starvation,
// registered one-cycle write pulse to the level-sensitive bank.
module reg_write_arbiter
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = reg_bank_pkg::DATA_W,
  parameter int NREGS    = reg_bank_pkg::NREGS,
  parameter int ADDR_W   = reg_bank_pkg::ADDR_W,
  parameter int MAX_WAIT = reg_bank_pkg::MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ldr_valid,
  output logic              ldr_ready,
  input  logic [ADDR_W-1:0] ldr_rd,
  input  logic [DATA_W-1:0] ldr_data,
  output logic [NREGS-1:0]  wr_enable,
  output logic [DATA_W-1:0] wr_data,
  output logic              pc_written,
  output logic              wr_conflict
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] RD_PC    = ADDR_W'(NREGS - 1);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic [NREGS-1:0]  r_wr_enable;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_pc_written;
  logic              r_wr_conflict;

  logic              w_alu_grant;
  logic              w_ldr_grant;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_rd;
  logic [DATA_W-1:0] w_data;
  logic [NREGS-1:0]  w_onehot;

  // LDR normally wins; an ALU request that has lost MAX_WAIT times in a row takes priority.
  assign w_alu_grant = rst_n && alu_valid && (!ldr_valid || (r_wait_cnt == WAIT_MAX));
  assign w_ldr_grant = rst_n && ldr_valid && !w_alu_grant;
  assign w_xfer      = w_alu_grant || w_ldr_grant;
  assign w_rd        = w_alu_grant ? alu_rd   : ldr_rd;
  assign w_data      = w_alu_grant ? alu_data : ldr_data;

  rf_onehot_decode #(
    .AW (ADDR_W),
    .N  (NREGS)
  ) u_decode (
    .i_en     (w_xfer),
    .i_addr   (w_rd),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt    <= '0;
      r_wr_enable   <= '0;
      r_wr_data     <= '0;
      r_pc_written  <= 1'b0;
      r_wr_conflict <= 1'b0;
    end else begin
      r_wr_enable   <= w_onehot;
      if (w_xfer) r_wr_data <= w_data;
      r_pc_written  <= w_xfer && (w_rd == RD_PC);
      r_wr_conflict <= alu_valid && ldr_valid && (alu_rd == ldr_rd);
      if (w_alu_grant || !alu_valid)
        r_wait_cnt <= '0;
      else if (r_wait_cnt != WAIT_MAX)
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  assign alu_ready   = w_alu_grant;
  assign ldr_ready   = w_ldr_grant;
  assign wr_enable   = r_wr_enable;
  assign wr_data     = r_wr_data;
  assign pc_written  = r_pc_written;
  assign wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: driver predicts grants and queues expected writes,
// monitor compares every cycle's bank outputs against the queue.
module tb_reg_write_arbiter;
  import reg_bank_pkg::*;

  localparam int MW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid, alu_ready, ldr_valid, ldr_ready;
  logic [3:0]  alu_rd, ldr_rd;
  logic [31:0] alu_data, ldr_data;
  logic [15:0] wr_enable;
  logic [31:0] wr_data;
  logic        pc_written, wr_conflict;

  always #5 clk = ~clk;

  reg_write_arbiter #(
    .DATA_W   (32),
    .NREGS    (16),
    .ADDR_W   (4),
    .MAX_WAIT (MW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ldr_valid   (ldr_valid),
    .ldr_ready   (ldr_ready),
    .ldr_rd      (ldr_rd),
    .ldr_data    (ldr_data),
    .wr_enable   (wr_enable),
    .wr_data     (wr_data),
    .pc_written  (pc_written),
    .wr_conflict (wr_conflict)
  );

  typedef struct {
    logic [15:0] en;
    logic [31:0] data;
    logic        pc;
    logic        conf;
  } wr_t;

  wr_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // pending requests held by the two upstream stages
  bit          a_pend = 0, l_pend = 0;
  logic [3:0]  a_rd = '0, l_rd = '0;
  logic [31:0] a_dat = '0, l_dat = '0;
  int          losses = 0;      // consecutive cycles the ALU request has been refused
  int          last_grant = 0;  // 0 none, 1 ALU, 2 LDR

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic new_alu(input logic [3:0] rd, input logic [31:0] d);
    a_pend = 1; a_rd = rd; a_dat = d;
  endtask

  task automatic new_ldr(input logic [3:0] rd, input logic [31:0] d);
    l_pend = 1; l_rd = rd; l_dat = d;
  endtask

  // One clock cycle, entered and left on a falling edge. drop=1 pulls reset low
  // after the handshake so the accepted write never reaches the bank.
  task automatic cycle(input bit rst_val, input bit drop);
    bit  ea, el;
    wr_t it;
    rst_n     = rst_val;
    alu_valid = a_pend; alu_rd = a_rd; alu_data = a_dat;
    ldr_valid = l_pend; ldr_rd = l_rd; ldr_data = l_dat;
    #1;
    ea = rst_val && a_pend && (!l_pend || losses >= MW);
    el = rst_val && l_pend && !ea;
    chk("alu_ready", alu_ready, ea);
    chk("ldr_ready", ldr_ready, el);
    last_grant = ea ? 1 : (el ? 2 : 0);
    if (rst_val && !drop && (ea || el)) begin
      it.en   = 16'h1 << (ea ? a_rd : l_rd);
      it.data = ea ? a_dat : l_dat;
      it.pc   = ((ea ? a_rd : l_rd) == 4'd15);
      it.conf = a_pend && l_pend && (a_rd == l_rd);
      exp_q.push_back(it);
    end
    if (!rst_val || drop)        losses = 0;
    else if (a_pend && !ea)      losses = (losses + 1 > MW) ? MW : losses + 1;
    else                         losses = 0;
    if (drop) begin
      rst_n  = 1'b0;
      a_pend = 0;
      l_pend = 0;
    end else begin
      if (ea) a_pend = 0;
      if (el) l_pend = 0;
    end
    @(negedge clk);
  endtask

  // Monitor: one expected write per accepted transfer, visible exactly one cycle later.
  initial begin
    logic        rs;
    logic [31:0] last;
    wr_t         it;
    last = '0;
    forever begin
      @(posedge clk);
      rs = rst_n;
      @(negedge clk);
      if (!rs) begin
        last = '0;
        chk("rst_wr_enable", wr_enable, 16'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_pc_written", pc_written, 1'b0);
        chk("rst_wr_conflict", wr_conflict, 1'b0);
      end else if (exp_q.size() > 0) begin
        it   = exp_q.pop_front();
        last = it.data;
        chk("wr_enable", wr_enable, it.en);
        chk("wr_data", wr_data, it.data);
        chk("pc_written", pc_written, it.pc);
        chk("wr_conflict", wr_conflict, it.conf);
      end else begin
        chk("idle_wr_enable", wr_enable, 16'h0);
        chk("idle_wr_data_hold", wr_data, last);
        chk("idle_pc_written", pc_written, 1'b0);
        chk("idle_wr_conflict", wr_conflict, 1'b0);
      end
    end
  end

  initial begin
    alu_valid = 0; ldr_valid = 0;
    alu_rd = '0; ldr_rd = '0; alu_data = '0; ldr_data = '0;
    @(negedge clk);

    // reset held three cycles with both requesters valid
    new_alu(4'd2, 32'h1111_2222);
    new_ldr(4'd4, 32'h3333_4444);
    repeat (3) cycle(0, 0);
    a_pend = 0; l_pend = 0;
    cycle(1, 0);

    // single ALU write, then one idle cycle
    new_alu(4'd5, 32'hDEAD_BEEF);
    cycle(1, 0);
    chk("single_alu_grant", last_grant, 1);
    cycle(1, 0);
    cycle(1, 0);

    // starvation bound: LDR,LDR,LDR,ALU repeating
    for (int i = 0; i < 12; i++) begin
      if (!a_pend) new_alu(4'($urandom_range(15, 0)), $urandom);
      if (!l_pend) new_ldr(4'($urandom_range(15, 0)), $urandom);
      cycle(1, 0);
      chk("starve_pattern", last_grant, (i % 4 == 3) ? 1 : 2);
    end
    for (int i = 0; i < 4 && (a_pend || l_pend); i++) cycle(1, 0);
    cycle(1, 0);

    // same-rd collision: LDR first with conflict flag, ALU next cycle
    new_alu(4'd7, 32'd2);
    new_ldr(4'd7, 32'd1);
    cycle(1, 0);
    chk("collide_first", last_grant, 2);
    cycle(1, 0);
    chk("collide_second", last_grant, 1);
    cycle(1, 0);

    // PC write pulse
    new_ldr(4'd15, 32'h100);
    cycle(1, 0);
    cycle(1, 0);
    cycle(1, 0);

    // reset right after an accepted ALU write drops it
    new_alu(4'd3, 32'hCAFE_0003);
    cycle(1, 1);
    cycle(0, 0);
    cycle(1, 0);

    // reset after ALU has lost twice and is about to lose again: counter must restart
    new_alu(4'd3, 32'hA0A0_0003);
    new_ldr(4'd9, 32'h9);
    cycle(1, 0);
    new_ldr(4'd10, 32'hA);
    cycle(1, 0);
    new_ldr(4'd11, 32'hB);
    cycle(1, 1);
    cycle(0, 0);
    chk("wait_cnt_after_reset", dut.r_wait_cnt, 2'd0);
    for (int i = 0; i < 4; i++) begin
      if (!a_pend) new_alu(4'($urandom_range(15, 0)), $urandom);
      if (!l_pend) new_ldr(4'($urandom_range(15, 0)), $urandom);
      cycle(1, 0);
      chk("post_reset_pattern", last_grant, (i == 3) ? 1 : 2);
    end
    for (int i = 0; i < 4 && (a_pend || l_pend); i++) cycle(1, 0);

    // randomized traffic with biased collisions and occasional resets
    for (int i = 0; i < 1500; i++) begin
      if (!a_pend && ($urandom_range(9, 0) < 6))
        new_alu(4'($urandom_range(15, 0)), $urandom);
      if (!l_pend && ($urandom_range(9, 0) < 6)) begin
        if (a_pend && ($urandom_range(3, 0) == 0)) new_ldr(a_rd, $urandom);
        else                                       new_ldr(4'($urandom_range(15, 0)), $urandom);
      end
      if ($urandom_range(199, 0) == 0) cycle(0, 0);
      else                             cycle(1, 0);
    end
    for (int i = 0; i < 8 && (a_pend || l_pend); i++) cycle(1, 0);
    a_pend = 0; l_pend = 0;
    cycle(1, 0);
    cycle(1, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
